// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN streaming stages.
package cnn_pkg;

    localparam int PKG_BITWIDTH = 8;
    localparam int PIPE_LATENCY = 3;

    typedef logic [PKG_BITWIDTH-1:0]        pixel_t;
    typedef logic signed [PKG_BITWIDTH-1:0] weight_t;

    // Product width plus enough growth bits to sum every kernel tap.
    function automatic int acc_width(input int bw, input int fsize);
        return 2 * bw + 1 + $clog2(fsize);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Enable-gated shift-register delay line holding one image row minus the window width.
module line_buffer
    import cnn_pkg::*;
#(
    parameter int bitwidth = 8,
    parameter int depth    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic [bitwidth-1:0] pixel,
    output logic [bitwidth-1:0] delayed
);

    logic [bitwidth-1:0] taps [depth];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < depth; k++) taps[k] <= '0;
        end else if (en) begin
            taps[0] <= pixel;
            for (int k = 1; k < depth; k++) taps[k] <= taps[k-1];
        end
    end

    assign delayed = taps[depth-1];

endmodule

// File: rtl/conv_window_stream.sv
// Streaming 2D convolution: line-buffered sliding window, signed kernel, shift/ReLU/saturate.
// Optional bias register enabled by defining CONV_BIAS_EN (written at weight_addr == filterSize).
module conv_window_stream
    import cnn_pkg::*;
#(
    parameter int bitwidth    = 8,
    parameter int filterWidth = 3,
    parameter int imageWidth  = 11,
    parameter int imageHeight = 11,
    parameter int outShift    = 0
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [bitwidth-1:0]                           data_in,
    input  logic                                          isValid,
    input  logic                                          weight_we,
    input  logic [$clog2(filterWidth*filterWidth)-1:0]    weight_addr,
    input  logic [bitwidth-1:0]                           weight_data,
    output logic [bitwidth-1:0]                           conv_out,
    output logic                                          convReady_out,
    output logic                                          frameDone_out
);

    localparam int FSIZE    = filterWidth * filterWidth;
    localparam int PROD_W   = 2 * bitwidth + 1;
    localparam int ACC_W    = acc_width(bitwidth, FSIZE);
    localparam int CW       = $clog2(imageWidth);
    localparam int RW       = $clog2(imageHeight);
    localparam int LB_DEPTH = imageWidth - filterWidth;

    localparam logic [CW-1:0] COL_LAST  = CW'(imageWidth - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(imageHeight - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(filterWidth - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(filterWidth - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << bitwidth) - 1);

    function automatic logic [bitwidth-1:0] relu_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> outShift;
        if (shifted < 0)            return '0;
        else if (shifted > OUT_MAX) return {bitwidth{1'b1}};
        else                        return bitwidth'(shifted);
    endfunction

    logic signed [bitwidth-1:0] weights [FSIZE];
    logic signed [ACC_W-1:0]    bias_ext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < FSIZE; k++) weights[k] <= '0;
        end else if (weight_we && int'(weight_addr) < FSIZE) begin
            weights[weight_addr] <= weight_data;
        end
    end

`ifdef CONV_BIAS_EN
    logic signed [bitwidth-1:0] bias;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                          bias <= '0;
        else if (weight_we && int'(weight_addr) == FSIZE)   bias <= weight_data;
    end

    assign bias_ext = ACC_W'(bias);
`else
    assign bias_ext = '0;
`endif

    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [bitwidth-1:0] win_p0 [filterWidth][filterWidth];
    logic [bitwidth-1:0] lb_tap [filterWidth-1];
    logic                vld_p0, last_p0;
    logic                win_valid, frame_last;

    assign win_valid  = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign frame_last = (row == ROW_LAST) && (col == COL_LAST);

    // Each line buffer takes the pixel leaving a window row and feeds the row above.
    for (genvar g = 0; g < filterWidth - 1; g++) begin : g_lb
        line_buffer #(
            .bitwidth (bitwidth),
            .depth    (LB_DEPTH)
        ) u_lb (
            .clock   (clock),
            .reset   (reset),
            .en      (isValid),
            .pixel   (win_p0[g+1][0]),
            .delayed (lb_tap[g])
        );
    end

    // Stage 0: window shift and raster position tracking on accepted pixels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col     <= '0;
            row     <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            for (int i = 0; i < filterWidth; i++)
                for (int j = 0; j < filterWidth; j++)
                    win_p0[i][j] <= '0;
        end else begin
            vld_p0  <= isValid && win_valid;
            last_p0 <= isValid && win_valid && frame_last;
            if (isValid) begin
                for (int i = 0; i < filterWidth; i++)
                    for (int j = 0; j < filterWidth - 1; j++)
                        win_p0[i][j] <= win_p0[i][j+1];
                for (int i = 0; i < filterWidth - 1; i++)
                    win_p0[i][filterWidth-1] <= lb_tap[i];
                win_p0[filterWidth-1][filterWidth-1] <= data_in;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Stage 1: per-tap signed products (pixel is zero-extended to stay non-negative).
    logic signed [PROD_W-1:0] prod_next [FSIZE];
    logic signed [PROD_W-1:0] prod_p1   [FSIZE];

    always_comb begin
        for (int k = 0; k < FSIZE; k++) begin
            prod_next[k] = PROD_W'($signed({1'b0, win_p0[k / filterWidth][k % filterWidth]}))
                         * PROD_W'(weights[k]);
        end
    end

    // Stage 2: sum of products plus optional bias.
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] acc_p2;

    always_comb begin
        acc_next = bias_ext;
        for (int k = 0; k < FSIZE; k++) acc_next = acc_next + ACC_W'(prod_p1[k]);
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < FSIZE; k++) prod_p1[k] <= prod_next[k];
        acc_p2 <= acc_next;
    end

    logic vld_p1, last_p1, vld_p2, last_p2;

    // Stage 3: shift, ReLU and clamp into the output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            last_p1       <= 1'b0;
            vld_p2        <= 1'b0;
            last_p2       <= 1'b0;
            conv_out      <= '0;
            convReady_out <= 1'b0;
            frameDone_out <= 1'b0;
        end else begin
            vld_p1        <= vld_p0;
            last_p1       <= last_p0;
            vld_p2        <= vld_p1;
            last_p2       <= last_p1;
            convReady_out <= vld_p2;
            frameDone_out <= vld_p2 && last_p2;
            if (vld_p2) conv_out <= relu_sat(acc_p2);
        end
    end

endmodule

// File: tb/tb_conv_window_stream.sv
// Randomized scoreboard bench for conv_window_stream against a 2D-array convolution model.
module tb_conv_window_stream;
    import cnn_pkg::*;

    localparam int W = 11;
    localparam int H = 11;
    localparam int F = 3;
    localparam int FS = F * F;
    localparam int OUT_SHIFT = 0;

    logic       clock = 1'b0;
    logic       reset;
    pixel_t     data_in;
    logic       isValid;
    logic       weight_we;
    logic [3:0] weight_addr;
    weight_t    weight_data;
    logic [7:0] conv_out;
    logic       convReady_out;
    logic       frameDone_out;

    conv_window_stream #(
        .bitwidth(8), .filterWidth(F), .imageWidth(W), .imageHeight(H), .outShift(OUT_SHIFT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .isValid       (isValid),
        .weight_we     (weight_we),
        .weight_addr   (weight_addr),
        .weight_data   (weight_data),
        .conv_out      (conv_out),
        .convReady_out (convReady_out),
        .frameDone_out (frameDone_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int val;
        int fd;
        int due;
    } exp_t;

    exp_t sb[$];
    int   got_vals[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   res_total = 0;
    int   fd_total = 0;

    int img[H][W];
    int wt[FS];
    int bias_m = 0;
    int mr = 0;
    int mc = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int model_conv(input int r, input int c);
        int acc;
        acc = bias_m;
        for (int i = 0; i < F; i++)
            for (int j = 0; j < F; j++)
                acc += img[r - F + 1 + i][c - F + 1 + j] * wt[i * F + j];
        acc = acc >>> OUT_SHIFT;
        if (acc < 0) return 0;
        if (acc > 255) return 255;
        return acc;
    endfunction

    task automatic send(input int p, input bit v);
        @(posedge clock); #1;
        weight_we = 1'b0;
        data_in   = pixel_t'(p);
        isValid   = v;
        if (v) begin
            img[mr][mc] = p;
            if (mr >= F - 1 && mc >= F - 1)
                sb.push_back('{val: model_conv(mr, mc), fd: int'(mr == H - 1 && mc == W - 1),
                               due: cyc + 1 + PIPE_LATENCY});
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic load_w(input int addr, input int v);
        @(posedge clock); #1;
        isValid     = 1'b0;
        weight_we   = 1'b1;
        weight_addr = 4'(addr);
        weight_data = weight_t'(v);
        if (addr < FS) wt[addr] = v;
`ifdef CONV_BIAS_EN
        else if (addr == FS) bias_m = v;
`endif
    endtask

    task automatic set_identity();
        for (int k = 0; k < FS; k++) load_w(k, (k == FS / 2) ? 1 : 0);
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < FS; k++) load_w(k, v);
    endtask

    // kind: 0 ramp row*W+col, 1 constant, 2 random; gap: 0 none, 1 alternate, 2 random idles
    task automatic send_frame(input int kind, input int cval, input int gap);
        int p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                p = (kind == 0) ? r * W + c : (kind == 1) ? cval : int'($urandom_range(0, 255));
                send(p, 1'b1);
                if (gap == 1) send(int'($urandom_range(0, 255)), 1'b0);
                if (gap == 2 && $urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 3)) send(int'($urandom_range(0, 255)), 1'b0);
            end
        end
    endtask

    task automatic drain();
        int t;
        send(0, 1'b0);
        t = 0;
        while (sb.size() > 0 && t < 50) begin
            @(posedge clock);
            t++;
        end
        repeat (2) @(posedge clock);
        check("drain_queue_empty", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        isValid   = 1'b0;
        weight_we = 1'b0;
        reset     = 1'b1;
        sb.delete();
        mr = 0;
        mc = 0;
        bias_m = 0;
        for (int k = 0; k < FS; k++) wt[k] = 0;
        @(negedge clock);
        check("reset_conv_out", conv_out, 0);
        check("reset_ready", convReady_out, 0);
        check("reset_frame_done", frameDone_out, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Monitor: pops an expectation for every result the DUT presents.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0 && sb[0].due < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL missing_result: got no pulse, expected value %0d at cycle %0d", sb[0].val, sb[0].due);
                void'(sb.pop_front());
            end
            if (convReady_out) begin
                res_total++;
                got_vals.push_back(int'(conv_out));
                if (frameDone_out) fd_total++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got value %0d at cycle %0d, expected no pulse", conv_out, cyc);
                end else begin
                    e = sb.pop_front();
                    check("conv_out", int'(conv_out), e.val);
                    check("frame_done", int'(frameDone_out), e.fd);
                    check("latency_cycle", cyc, e.due);
                end
            end else if (frameDone_out) begin
                n_cmp++;
                n_err++;
                $display("FAIL stray_frame_done: got pulse without result at cycle %0d, expected none", cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, f0, bad;
        reset       = 1'b1;
        data_in     = '0;
        isValid     = 1'b0;
        weight_we   = 1'b0;
        weight_addr = '0;
        weight_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("init_conv_out", conv_out, 0);
        check("init_ready", convReady_out, 0);
        check("init_frame_done", frameDone_out, 0);
        #1 reset = 1'b0;

        // Identity kernel over a ramp frame.
        set_identity();
        r0 = res_total; f0 = fd_total; got_vals.delete();
        send_frame(0, 0, 0);
        drain();
        check("ident_count", res_total - r0, 81);
        check("ident_frames", fd_total - f0, 1);
        check("ident_first", got_vals.size() > 0 ? got_vals[0] : -1, 12);
        check("ident_last", got_vals.size() > 0 ? got_vals[got_vals.size() - 1] : -1, 108);

        // Saturation: all ones over 255.
        set_all(1);
        got_vals.delete();
        send_frame(1, 255, 0);
        drain();
        bad = 0;
        foreach (got_vals[i]) if (got_vals[i] != 255) bad++;
        check("sat_count", got_vals.size(), 81);
        check("sat_non255", bad, 0);

        // ReLU: all minus ones over 10.
        set_all(-1);
        got_vals.delete();
        send_frame(1, 10, 0);
        drain();
        bad = 0;
        foreach (got_vals[i]) if (got_vals[i] != 0) bad++;
        check("relu_count", got_vals.size(), 81);
        check("relu_nonzero", bad, 0);

        // Identity with isValid alternating.
        set_identity();
        r0 = res_total; got_vals.delete();
        send_frame(0, 0, 1);
        drain();
        check("toggle_count", res_total - r0, 81);
        check("toggle_last", got_vals.size() > 0 ? got_vals[got_vals.size() - 1] : -1, 108);

        // Reset in the middle of a frame, then a clean frame.
        set_identity();
        for (int r = 0; r < H && !(mr == 5 && mc == 6); r++)
            for (int c = 0; c < W && !(mr == 5 && mc == 6); c++)
                send(r * W + c, 1'b1);
        do_reset();
        set_identity();
        r0 = res_total; f0 = fd_total; got_vals.delete();
        send_frame(0, 0, 0);
        drain();
        check("post_reset_count", res_total - r0, 81);
        check("post_reset_frames", fd_total - f0, 1);
        check("post_reset_first", got_vals.size() > 0 ? got_vals[0] : -1, 12);

        // Random kernel, two back-to-back frames, no gaps.
        for (int k = 0; k < FS; k++) load_w(k, int'($urandom_range(0, 255)) - 128);
        load_w(FS, int'($urandom_range(0, 100)));
        r0 = res_total; f0 = fd_total;
        send_frame(2, 0, 0);
        send_frame(2, 0, 0);
        drain();
        check("b2b_count", res_total - r0, 162);
        check("b2b_frames", fd_total - f0, 2);

        // Random small kernel with random idle gaps.
        for (int k = 0; k < FS; k++) load_w(k, int'($urandom_range(0, 6)) - 3);
        r0 = res_total;
        send_frame(2, 0, 2);
        drain();
        check("gap_count", res_total - r0, 81);

`ifdef CONV_BIAS_EN
        do_reset();
        load_w(FS, 5);
        got_vals.delete();
        send_frame(2, 0, 0);
        drain();
        bad = 0;
        foreach (got_vals[i]) if (got_vals[i] != 5) bad++;
        check("bias_count", got_vals.size(), 81);
        check("bias_not5", bad, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_stream.md
Name: conv_window_stream

Overview:
- Streaming 2D convolution stage directly upstream of the max-pool stage.
- Accepts a raster-scan pixel stream, builds a filterWidth x filterWidth sliding window using line buffers, and multiplies the window by a loadable signed kernel.
- Applies shift, ReLU and saturation, then emits one unsigned result per valid window position.
- Outputs drive the max-pool stage's data_in/isValid directly.

Parameters:
- bitwidth, 8, pixel, weight and output width.
- filterWidth, 3, kernel side length.
- imageWidth, 11, pixels per image row.
- imageHeight, 11, rows per frame.
- outShift, 0, arithmetic right shift applied to the accumulator before clamping.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  bitwidth  unsigned pixel.
- isValid  in  1  data_in valid this cycle.
- weight_we  in  1  kernel write strobe.
- weight_addr  in  clog2(filterWidth*filterWidth)  kernel index, raster order.
- weight_data  in  bitwidth  signed two's-complement weight.
- conv_out  out  bitwidth  unsigned result.
- convReady_out  out  1  conv_out valid, one-cycle pulse per result.
- frameDone_out  out  1  one-cycle pulse when the last result of a frame is emitted.

Behaviour:
- Reset: conv_out=0, convReady_out=0, frameDone_out=0; col/row counters=0; pipeline valid tags=0; window and line buffers cleared to 0. Weights are also cleared to 0.
- Reset mid-frame discards all partial state. The next isValid pixel is treated as (row 0, col 0).
- Pixel acceptance:
  - Only cycles with isValid=1 shift the window, advance the line buffers and advance col.
  - col wraps at imageWidth-1 and increments row.
  - row wraps at imageHeight-1 back to 0, so a new frame can follow with no gap.
- Window: window[i][j] holds pixel (r-filterWidth+1+i, c-filterWidth+1+j) relative to the pixel just accepted at (r,c).
- Window valid: asserted when the accepted pixel has r>=filterWidth-1 and c>=filterWidth-1.
  - This gives (imageWidth-filterWidth+1)*(imageHeight-filterWidth+1) results per frame (81 at defaults).
  - Positions that straddle a row wrap never produce output.
- Pipeline: 3 stages, free-running (does not stall on isValid gaps), each stage carrying a valid tag.
  - S1: filterSize signed products, 2*bitwidth+1 bits.
  - S2: adder tree into the accumulator, accWidth = 2*bitwidth+1+clog2(filterSize) bits.
  - S3: arithmetic shift by outShift; if negative output 0 (ReLU); if >2^bitwidth-1 output 2^bitwidth-1; else low bitwidth bits.
- Latency: convReady_out rises exactly 3 clocks after the accepting edge of a window-valid pixel. Throughput is 1 result per clock.
- frameDone_out pulses in the same cycle as convReady_out for the result from pixel (imageHeight-1, imageWidth-1).
- Weights:
  - Written synchronously when weight_we=1; usable by the window the following cycle.
  - Writes during an active frame are not blocked; results in flight may mix old and new weights.
  - Software loads weights between frames only.
- Simultaneous weight_we and isValid: both take effect. S1 on that edge uses the old weight.
- No backpressure: the downstream stage must accept every convReady_out pulse.

Optional Feature:
- CONV_BIAS_EN:
  - Defined: one extra signed bitwidth-bit bias register, written via weight_addr == filterSize.
  - The bias is sign-extended and added in S2 before the shift. Reset value 0. Latency unchanged.
- Undefined: no bias register; weight_addr == filterSize writes are ignored.

Decomposition:
- Package cnn_pkg holds:
  - typedefs for pixel_t (unsigned bitwidth) and weight_t (signed bitwidth);
  - a function acc_width(bitwidth, filterSize);
  - constant PIPE_LATENCY=3.
- Sub-module line_buffer: enable-gated FIFO-style delay of imageWidth-filterWidth entries with asynchronous reset. filterWidth-1 instances are generated.

Test Plan:
- Identity kernel (weight[4]=1, others 0), frame pixel=row*11+col:
  - 81 pulses; first conv_out=12, last=108.
  - Each result arrives 3 clocks after pixel (2,2) and successors.
  - frameDone_out coincides with the 81st pulse.
- All weights 1, all pixels 255: every conv_out=255 (sum 2295 saturated).
- All weights -1, pixels 10: every conv_out=0 (ReLU of -90).
- Identity kernel with isValid toggling 1,0,1,0: identical 81-value sequence; no pulses are spawned by idle cycles.
- Reset asserted at pixel (5,5), then a fresh frame: no stale outputs, and the new frame matches the identity test.
- Two back-to-back frames with no gap: exactly 2 frameDone_out pulses and 162 results. With CONV_BIAS_EN, zero weights and bias=5, every output is 5.
